// File: rtl/serial_to_parallel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_to_parallel_pkg
// Description : Shared framing constants, FSM state encoding and parity helper
//               for the serial-to-parallel receiver.
// Revision    : 1.0  initial release
// ============================================================================
package serial_to_parallel_pkg;

  // Frame layout: start + data + parity + stop
  localparam int   FRAME_LEN   = 11;
  localparam int   DATA_BITS   = 8;

  // Parity mode: even parity, so data bits XOR parity bit must equal this value
  localparam logic PARITY_MODE = 1'b0;

  // Receiver framing FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // True when the received data byte and parity bit satisfy the parity mode
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] data,
                                     input logic                 par);
    return ((^data) ^ par) == PARITY_MODE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_to_parallel_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_fifo
// Description : Small synchronous FIFO holding received bytes. The head word is
//               shown on dout (0 while empty). A pop and a push in the same
//               cycle both complete, even when the FIFO is full.
// Revision    : 1.0  initial release
// ============================================================================
module rx_fifo #(
  parameter int N     = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [2:0]       level
);

  logic [WIDTH-1:0] r_mem [N];
  logic [2:0]       r_wr_ptr;
  logic [2:0]       r_rd_ptr;
  logic [2:0]       r_level;
  logic             w_pop;
  logic             w_push;

  // Pointer advance with wrap at the configured depth
  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == 3'(N - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  // A pop of an empty FIFO is a no-op; a pop frees the slot a full-FIFO push needs
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  assign empty  = (r_level == 3'd0);
  assign full   = (r_level == 3'(N));
  assign level  = r_level;
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array, written on an accepted push (contents need no reset)
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= 3'd0;
      r_rd_ptr <= 3'd0;
      r_level  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module      : serial_to_parallel
// Description : Receives 11-bit serial frames (start, 8 data LSB first, even
//               parity, stop) sampled on en_i cycles, checks them and stores
//               good bytes in a receive FIFO of depth N.
// Revision    : 1.0  initial release
// ============================================================================
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int N = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       data_i,
  input  logic       rd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic [2:0] level_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overflow_o
);

  state_t               r_state;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overflow;

  logic                 w_par_ok;
  logic                 w_push;
  logic                 w_empty;
  logic                 w_full;

  // Push happens on the stop-bit edge itself so the byte is visible one cycle later
  assign w_par_ok = parity_ok(r_shift, r_parity);
  assign w_push   = (r_state == ST_STOP) && en_i && data_i && w_par_ok;

  // Framing FSM with one-cycle registered error/overflow pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en_i && !data_i) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= 3'd0;
          end
        end
        ST_DATA: begin
          if (!en_i) begin
            r_state     <= ST_IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_shift   <= {data_i, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'(DATA_BITS - 1)) r_state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (!en_i) begin
            r_state     <= ST_IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_parity <= data_i;
            r_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_state <= ST_IDLE;
          if (!en_i) begin
            r_frame_err <= 1'b1;
          end else begin
            r_frame_err  <= !data_i;
            r_parity_err <= !w_par_ok;
            // A full FIFO with no simultaneous pop drops the good byte
            r_overflow   <= w_push && w_full && !rd_i;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rx_fifo #(
    .N     (N),
    .WIDTH (DATA_BITS)
  ) u_rx_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (w_push),
    .pop   (rd_i),
    .din   (r_shift),
    .dout  (data_o),
    .empty (w_empty),
    .full  (w_full),
    .level (level_o)
  );

  assign valid_o      = !w_empty;
  assign parity_err_o = r_parity_err;
  assign frame_err_o  = r_frame_err;
  assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_to_parallel
// Description : Scoreboard bench for serial_to_parallel. Stimulus pushes the
//               bytes it expects to read back; a monitor compares each popped
//               head byte and counts the error/overflow pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_to_parallel;
  import serial_to_parallel_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       data_i;
  logic       rd_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic [2:0] level_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters seen by the monitor, and the counts the stimulus expects
  int seen_par = 0, seen_frm = 0, seen_ovf = 0;
  int exp_par  = 0, exp_frm  = 0, exp_ovf  = 0;

  logic [7:0] sb_q [$];

  serial_to_parallel #(.N(5)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .data_i       (data_i),
    .rd_i         (rd_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .level_o      (level_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: on every accepted pop compare the head byte with the scoreboard
  always @(negedge clk_i) begin
    if (parity_err_o) seen_par++;
    if (frame_err_o)  seen_frm++;
    if (overflow_o)   seen_ovf++;
    if (!rst_i && rd_i && valid_o) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no data", data_o);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        if (data_o !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h", data_o, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Send one frame LSB first; en_i stays high afterwards so frames can abut.
  // rd_stop raises rd_i during the stop-bit cycle only.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input logic rd_stop);
    logic [FRAME_LEN-1:0] fr;
    fr = {stp, par, b, 1'b0};
    for (int i = 0; i < FRAME_LEN; i++) begin
      en_i   = 1'b1;
      data_i = fr[i];
      rd_i   = (i == FRAME_LEN - 1) ? rd_stop : 1'b0;
      tick();
    end
    rd_i = 1'b0;
  endtask

  task automatic idle_line();
    en_i   = 1'b0;
    data_i = 1'b1;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_i = 1'b1;
      tick();
    end
    rd_i = 1'b0;
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_par_err_cnt"}, seen_par, exp_par);
    check({tag, "_frm_err_cnt"}, seen_frm, exp_frm);
    check({tag, "_ovf_cnt"},     seen_ovf, exp_ovf);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; data_i = 1'b1; rd_i = 1'b0;
    tick(3);
    // Reset state
    check("rst_data_o",  data_o,  0);
    check("rst_valid_o", valid_o, 0);
    check("rst_level_o", level_o, 0);
    check("rst_pulses",  {parity_err_o, frame_err_o, overflow_o}, 0);
    rst_i = 1'b0;

    // Good 0xA5 frame starting in the first cycle after reset release
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle_line();
    check("a5_valid", valid_o, 1);
    check("a5_data",  data_o,  8'hA5);
    check("a5_level", level_o, 1);
    tick(2);
    check_pulses("a5");
    pop_n(1);
    check("a5_level_after_pop", level_o, 0);
    check("a5_valid_after_pop", valid_o, 0);

    // Pop of an empty FIFO is ignored
    pop_n(2);
    check("empty_pop_level", level_o, 0);

    // 0x3C with wrong parity, then with stop bit 0
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    idle_line();
    exp_par++;
    tick(3);
    check("3c_par_level", level_o, 0);
    check_pulses("3c_par");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle_line();
    exp_frm++;
    tick(3);
    check("3c_stop_level", level_o, 0);
    check_pulses("3c_stop");

    // Six back-to-back frames into a depth-5 FIFO: the 6th overflows
    sb_q.push_back(8'h01); send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    sb_q.push_back(8'h02); send_frame(8'h02, 1'b1, 1'b1, 1'b0);
    sb_q.push_back(8'h03); send_frame(8'h03, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(8'h04); send_frame(8'h04, 1'b1, 1'b1, 1'b0);
    sb_q.push_back(8'h05); send_frame(8'h05, 1'b0, 1'b1, 1'b0);
    send_frame(8'h06, 1'b0, 1'b1, 1'b0);
    idle_line();
    exp_ovf++;
    check("ovf_level", level_o, 5);
    tick(2);
    check_pulses("ovf");
    pop_n(5);
    check("ovf_drain_level", level_o, 0);

    // Full FIFO with a pop in the 6th frame's push cycle: no overflow
    sb_q.push_back(8'h01); send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    sb_q.push_back(8'h02); send_frame(8'h02, 1'b1, 1'b1, 1'b0);
    sb_q.push_back(8'h03); send_frame(8'h03, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(8'h04); send_frame(8'h04, 1'b1, 1'b1, 1'b0);
    sb_q.push_back(8'h05); send_frame(8'h05, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(8'h06); send_frame(8'h06, 1'b0, 1'b1, 1'b1);
    idle_line();
    check("pushpop_level", level_o, 5);
    tick(2);
    check_pulses("pushpop");
    pop_n(5);
    check("pushpop_drain_level", level_o, 0);

    // Abort after 4 data bits, then a good 0x7E frame
    en_i = 1'b1; data_i = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      data_i = i[0];
      tick();
    end
    idle_line();
    exp_frm++;
    tick(3);
    check("abort_level", level_o, 0);
    check_pulses("abort");
    sb_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0);
    idle_line();
    check("7e_level", level_o, 1);
    check("7e_data",  data_o,  8'h7E);
    tick(2);
    check_pulses("7e");
    pop_n(1);

    // Three stored bytes, then reset in the middle of a frame
    sb_q.push_back(8'h11); send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(8'h22); send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(8'h33); send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    check("prerst_level", level_o, 3);
    en_i = 1'b1; data_i = 1'b0; tick();
    data_i = 1'b1; tick(2);
    rst_i = 1'b1; rd_i = 1'b1;
    tick();
    sb_q.delete();
    rst_i = 1'b0; rd_i = 1'b0;
    check("rst_mid_level", level_o, 0);
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_data",  data_o,  0);
    check("rst_mid_pulses", {parity_err_o, frame_err_o, overflow_o}, 0);
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    idle_line();
    check("55_level", level_o, 1);
    check("55_data",  data_o,  8'h55);
    tick(2);
    check_pulses("55");
    pop_n(1);
    tick(2);
    check("sb_empty_at_end", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on simulation time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
